core_dmem_resp: RTL and testbench

Data-memory responder: the target end of the core's load/store request interface. Accepts one request at a time (address, byte strobe, write flag, sign flags) and performs byte-lane writes into an internal word array, or reads a word and returns it lane-aligned and sign/zero-extended, ready for register writeback. Sits between the core memory-control stage and the register-file writeback path; configurable wait states model slower memories.

---
 rtl/core_dmem_resp.sv | 179 +++++++++++++++++
 tb/tb_core_dmem_resp.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_dmem_resp.sv
// Data-memory responder: byte-lane stores and lane-aligned, sign/zero-extended loads with configurable wait states.
// Optional macro DMEM_ALIGN_CHECK_EN: also reject requests whose REQ_ADDR[1:0] disagrees with the strobe lane.
module core_dmem_resp #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [31:0] REQ_ADDR,
  input  logic [3:0]  REQ_STRB,
  input  logic [31:0] REQ_WDATA,
  input  logic        REQ_LOADBS,
  input  logic        REQ_LOADHWS,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d, bs_q, bs_d, hs_q, hs_d;
  logic [31:0]     addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]      strb_q, strb_d;
  logic            rdy_d, rvalid_d, rerr_d;
  logic [31:0]     rdata_d;
  logic            mem_wr;

  logic [31:0]     mem [DEPTH_WORDS];

  logic [31:0]     idx_wide;
  logic [AW-1:0]   idx;
  logic [1:0]      lane_k;
  size_t           size;
  logic            strb_ok, acc_err;
  logic [31:0]     wlane, rd_word, shifted, load_data;

  // Strobe decode: legal patterns, access size and lowest lane
  always_comb begin
    strb_ok = 1'b1;
    lane_k  = 2'd0;
    size    = SZ_WORD;
    unique case (strb_q)
      4'b0001: begin size = SZ_BYTE; lane_k = 2'd0; end
      4'b0010: begin size = SZ_BYTE; lane_k = 2'd1; end
      4'b0100: begin size = SZ_BYTE; lane_k = 2'd2; end
      4'b1000: begin size = SZ_BYTE; lane_k = 2'd3; end
      4'b0011: begin size = SZ_HALF; lane_k = 2'd0; end
      4'b1100: begin size = SZ_HALF; lane_k = 2'd2; end
      4'b1111: begin size = SZ_WORD; lane_k = 2'd0; end
      default: strb_ok = 1'b0;
    endcase
  end

  // Address range, error evaluation and data steering for the ACCESS cycle
  always_comb begin
    idx_wide = (addr_q - BASE_ADDR) >> 2;
    idx      = idx_wide[AW-1:0];
    acc_err  = !strb_ok || (idx_wide >= 32'(DEPTH_WORDS));
`ifdef DMEM_ALIGN_CHECK_EN
    if (addr_q[1:0] != lane_k) acc_err = 1'b1;
`endif
    unique case (size)
      SZ_BYTE: wlane = {4{wdata_q[7:0]}};
      SZ_HALF: wlane = {2{wdata_q[15:0]}};
      default: wlane = wdata_q;
    endcase
    rd_word = mem[idx];
    shifted = rd_word >> {lane_k, 3'b000};
    unique case (size)
      SZ_BYTE: load_data = bs_q ? {{24{shifted[7]}}, shifted[7:0]} : {24'd0, shifted[7:0]};
      SZ_HALF: load_data = hs_q ? {{16{shifted[15]}}, shifted[15:0]} : {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    strb_d   = strb_q;
    wdata_d  = wdata_q;
    bs_d     = bs_q;
    hs_d     = hs_q;
    rdy_d    = 1'b0;
    rvalid_d = RSP_VALID;
    rdata_d  = RSP_RDATA;
    rerr_d   = RSP_ERR;
    mem_wr   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        rdy_d = 1'b1;
        if (REQ_VALID && REQ_READY) begin
          we_d    = REQ_WE;
          addr_d  = REQ_ADDR;
          strb_d  = REQ_STRB;
          wdata_d = REQ_WDATA;
          bs_d    = REQ_LOADBS;
          hs_d    = REQ_LOADHWS;
          rdy_d   = 1'b0;
          if (WAIT_STATES != 0) begin
            state_d = S_WAIT;
            cnt_d   = CW'(WAIT_STATES);
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        rvalid_d = 1'b1;
        rerr_d   = acc_err;
        rdata_d  = (acc_err || we_q) ? 32'd0 : load_data;
        mem_wr   = we_q && !acc_err;
        state_d  = S_RESP;
      end
      default: begin
        if (RSP_READY) begin
          rvalid_d = 1'b0;
          rdy_d    = 1'b1;
          state_d  = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      strb_q    <= '0;
      wdata_q   <= '0;
      bs_q      <= 1'b0;
      hs_q      <= 1'b0;
      REQ_READY <= 1'b0;
      RSP_VALID <= 1'b0;
      RSP_RDATA <= '0;
      RSP_ERR   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      strb_q    <= strb_d;
      wdata_q   <= wdata_d;
      bs_q      <= bs_d;
      hs_q      <= hs_d;
      REQ_READY <= rdy_d;
      RSP_VALID <= rvalid_d;
      RSP_RDATA <= rdata_d;
      RSP_ERR   <= rerr_d;
    end
  end

  // Array is never reset; a write is suppressed if reset coincides with ACCESS
  always_ff @(posedge CLK) begin
    if (NRST && mem_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (strb_q[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_core_dmem_resp.sv
// Scoreboard bench for core_dmem_resp: reference model pushes expected responses, responses are popped and compared.
// Honours DMEM_ALIGN_CHECK_EN in its model when defined.
module tb_core_dmem_resp;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned WS    = 1;

  logic        CLK = 1'b0;
  logic        NRST = 1'b0;
  logic        REQ_VALID = 1'b0, REQ_WE = 1'b0, REQ_LOADBS = 1'b0, REQ_LOADHWS = 1'b0;
  logic [31:0] REQ_ADDR = '0, REQ_WDATA = '0;
  logic [3:0]  REQ_STRB = '0;
  logic        RSP_READY = 1'b0;
  logic        REQ_READY, RSP_VALID, RSP_ERR;
  logic [31:0] RSP_RDATA;

  typedef struct packed { logic [31:0] rdata; logic err; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] mdl [DEPTH];
  int          tests_run = 0;
  int          tests_failed = 0;

  core_dmem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS), .BASE_ADDR(32'h0)) dut (
    .CLK(CLK), .NRST(NRST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
    .REQ_ADDR(REQ_ADDR), .REQ_STRB(REQ_STRB), .REQ_WDATA(REQ_WDATA), .REQ_LOADBS(REQ_LOADBS),
    .REQ_LOADHWS(REQ_LOADHWS), .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR));

  always #5 CLK = ~CLK;

  // Reference model: updates the shadow array and returns the expected response
  function automatic exp_t model(input logic we, input logic [31:0] addr, input logic [3:0] strb,
                                 input logic [31:0] wd, input logic bs, input logic hs);
    exp_t        e;
    int          k, sz;
    logic [31:0] idx, w;
    logic [7:0]  b;
    logic [15:0] h;
    e.err = 1'b0; e.rdata = '0; k = 0; sz = 4;
    idx = addr >> 2;
    case (strb)
      4'b0001: begin k = 0; sz = 1; end
      4'b0010: begin k = 1; sz = 1; end
      4'b0100: begin k = 2; sz = 1; end
      4'b1000: begin k = 3; sz = 1; end
      4'b0011: begin k = 0; sz = 2; end
      4'b1100: begin k = 2; sz = 2; end
      4'b1111: begin k = 0; sz = 4; end
      default: e.err = 1'b1;
    endcase
    if (idx >= DEPTH) e.err = 1'b1;
`ifdef DMEM_ALIGN_CHECK_EN
    if (32'(addr[1:0]) != 32'(k)) e.err = 1'b1;
`endif
    if (e.err) return e;
    if (we) begin
      for (int i = 0; i < sz; i++) mdl[idx][8*(k+i) +: 8] = wd[8*i +: 8];
    end else begin
      w = mdl[idx];
      b = w[8*k +: 8];
      h = w[8*k +: 16];
      if (sz == 1)      e.rdata = bs ? {{24{b[7]}}, b} : {24'd0, b};
      else if (sz == 2) e.rdata = hs ? {{16{h[15]}}, h} : {16'd0, h};
      else              e.rdata = w;
    end
    return e;
  endfunction

  // Called at a negedge; returns just after the accepting posedge
  task automatic send(input logic we, input logic [31:0] addr, input logic [3:0] strb,
                      input logic [31:0] wd, input logic bs, input logic hs);
    int n = 0;
    while (REQ_READY !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
    tests_run++;
    if (REQ_READY !== 1'b1) begin
      tests_failed++;
      $display("FAIL req_ready_wait: REQ_READY=%b, required 1", REQ_READY);
    end
    REQ_VALID = 1'b1; REQ_WE = we; REQ_ADDR = addr; REQ_STRB = strb;
    REQ_WDATA = wd; REQ_LOADBS = bs; REQ_LOADHWS = hs;
    exp_q.push_back(model(we, addr, strb, wd, bs, hs));
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
  endtask

  // Waits for the response, optionally stalls it, pops and compares, then handshakes
  task automatic recv(input int hold);
    int          lat = 0;
    logic [31:0] rd0;
    exp_t        e;
    @(negedge CLK);
    while (RSP_VALID !== 1'b1 && lat < 40) begin @(negedge CLK); lat++; end
    // Edges after the accepting edge before RSP_VALID is seen: WAIT_STATES+1
    tests_run++;
    if (lat != int'(WS) + 1) begin
      tests_failed++;
      $display("FAIL rsp_latency: got %0d edges, required %0d", lat, WS + 1);
    end
    rd0 = RSP_RDATA;
    for (int i = 0; i < hold; i++) begin
      tests_run++;
      if (RSP_VALID !== 1'b1 || RSP_RDATA !== rd0 || REQ_READY !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_hold: valid=%b rdata=%h ready=%b, required 1 %h 0",
                 RSP_VALID, RSP_RDATA, REQ_READY, rd0);
      end
      @(negedge CLK);
    end
    RSP_READY = 1'b1;
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL scoreboard_empty: response with nothing expected");
    end else begin
      e = exp_q.pop_front();
      if (RSP_RDATA !== e.rdata || RSP_ERR !== e.err) begin
        tests_failed++;
        $display("FAIL rsp_data: rdata=%h err=%b, required rdata=%h err=%b",
                 RSP_RDATA, RSP_ERR, e.rdata, e.err);
      end
    end
    @(posedge CLK); #1;
    RSP_READY = 1'b0;
    @(negedge CLK);
    tests_run++;
    if (RSP_VALID !== 1'b0 || REQ_READY !== 1'b1) begin
      tests_failed++;
      $display("FAIL post_handshake: valid=%b ready=%b, required 0 1", RSP_VALID, REQ_READY);
    end
  endtask

  task automatic xact(input logic we, input logic [31:0] addr, input logic [3:0] strb,
                      input logic [31:0] wd, input logic bs, input logic hs);
    send(we, addr, strb, wd, bs, hs);
    recv(0);
  endtask

  task automatic test_reset;
    NRST = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    tests_run++;
    if (REQ_READY !== 1'b0 || RSP_VALID !== 1'b0 || RSP_RDATA !== 32'd0 || RSP_ERR !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: ready=%b valid=%b rdata=%h err=%b, required 0 0 0 0",
               REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR);
    end
    NRST = 1'b1;
    @(negedge CLK);
    tests_run++;
    if (REQ_READY !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release_ready: REQ_READY=%b, required 1", REQ_READY);
    end
  endtask

  task automatic test_word;
    xact(1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 1'b0, 1'b0);
    xact(1'b0, 32'h10, 4'b1111, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_byte;
    xact(1'b1, 32'h10, 4'b1111, 32'h0, 1'b0, 1'b0);
    xact(1'b1, 32'h12, 4'b0100, 32'h85, 1'b0, 1'b0);
    xact(1'b0, 32'h12, 4'b0100, 32'h0, 1'b1, 1'b0);
    xact(1'b0, 32'h12, 4'b0100, 32'h0, 1'b0, 1'b0);
    xact(1'b0, 32'h10, 4'b1111, 32'h0, 1'b0, 1'b0);
    xact(1'b0, 32'h12, 4'b0100, 32'h0, 1'b1, 1'b1);
  endtask

  task automatic test_half;
    xact(1'b1, 32'h20, 4'b1111, 32'h11223344, 1'b0, 1'b0);
    xact(1'b1, 32'h22, 4'b1100, 32'h8001, 1'b0, 1'b0);
    xact(1'b0, 32'h22, 4'b1100, 32'h0, 1'b0, 1'b1);
    xact(1'b0, 32'h22, 4'b1100, 32'h0, 1'b0, 1'b0);
    xact(1'b0, 32'h20, 4'b1111, 32'h0, 1'b0, 1'b0);
    xact(1'b0, 32'h20, 4'b0011, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_errors;
    xact(1'b1, 32'h30, 4'b1111, 32'h55AA55AA, 1'b0, 1'b0);
    xact(1'b1, 32'h30, 4'b0110, 32'hFFFFFFFF, 1'b0, 1'b0);
    xact(1'b1, 32'h30, 4'b0000, 32'hFFFFFFFF, 1'b0, 1'b0);
    xact(1'b0, 32'h30, 4'b1111, 32'h0, 1'b0, 1'b0);
    xact(1'b0, 32'(DEPTH * 4), 4'b1111, 32'h0, 1'b0, 1'b0);
    xact(1'b1, 32'(DEPTH * 4), 4'b1111, 32'h12345678, 1'b0, 1'b0);
    xact(1'b0, 32'h0, 4'b1111, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_stall;
    xact(1'b1, 32'h40, 4'b1111, 32'hA5A5_0F0F, 1'b0, 1'b0);
    send(1'b0, 32'h40, 4'b1111, 32'h0, 1'b0, 1'b0);
    recv(5);
  endtask

  task automatic test_reset_mid;
    xact(1'b1, 32'h50, 4'b1111, 32'h1111_1111, 1'b0, 1'b0);
    // Store accepted then aborted by reset while in WAIT; model stays unchanged
    REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = 32'h50; REQ_STRB = 4'b1111; REQ_WDATA = 32'h2222_2222;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    @(negedge CLK);
    NRST = 1'b0;
    @(posedge CLK); #1;
    tests_run++;
    if (RSP_VALID !== 1'b0 || REQ_READY !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_in_wait: valid=%b ready=%b, required 0 0", RSP_VALID, REQ_READY);
    end
    @(negedge CLK);
    NRST = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      tests_run++;
      if (RSP_VALID !== 1'b0) begin
        tests_failed++;
        $display("FAIL dropped_response: RSP_VALID=%b, required 0", RSP_VALID);
      end
    end
    xact(1'b0, 32'h50, 4'b1111, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_align;
    xact(1'b1, 32'h60, 4'b1111, 32'h0, 1'b0, 1'b0);
    xact(1'b1, 32'h63, 4'b0001, 32'h7E, 1'b0, 1'b0);
    xact(1'b0, 32'h60, 4'b1111, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [3:0]  strbs [7];
    logic [31:0] a;
    logic [3:0]  s;
    int          k;
    strbs = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    for (int i = 0; i < 8; i++) xact(1'b1, 32'h80 + 32'(4 * i), 4'b1111, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      s = strbs[$urandom_range(6)];
      k = (s[0]) ? 0 : (s[1]) ? 1 : (s[2]) ? 2 : 3;
      a = 32'h80 + 32'(4 * $urandom_range(7)) + 32'(k);
      xact(1'b1, a, s, $urandom, 1'b0, 1'b0);
      xact(1'b0, a, s, 32'h0, 1'($urandom_range(1)), 1'($urandom_range(1)));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_word;
    test_byte;
    test_half;
    test_errors;
    test_stall;
    test_reset_mid;
    test_align;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
